// File: rtl/dist_ram_pkg.sv
// Shared types and sizing helpers for the distributed-RAM read-stream engine.
//   rd_state_t  : engine FSM state (IDLE, ISSUE, DRAIN)
//   buf_depth() : output buffer depth needed to cover the RAM read latency
//   cnt_width() : width of a counter that can hold 0..depth
package dist_ram_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } rd_state_t;

  // One slot per read still inside the RAM pipeline, one for the word being
  // presented downstream, and one so a full-rate stream never bubbles.
  function automatic int buf_depth(input int rd_latency);
    return rd_latency + 2;
  endfunction

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/dist_ram_rd_stream_if.sv
// Bundle of the command, RAM read-port and output-stream signals of the
// read-stream engine.
//   master : the engine side (drives cmd_ready, ram_raddr, m_valid/m_data/m_last)
//   slave  : the environment side (command source, RAM, consumer)
//
// Handshake rule for both cmd_* and m_*: a transfer happens on a rising clock
// edge where valid and ready are both 1. A source that raises valid keeps it
// high, with its payload unchanged, until that transfer; ready may change
// freely and never depends on the payload.
interface dist_ram_rd_stream_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int WORD_WIDTH = 32,
  parameter int LEN_WIDTH  = 8
);

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [LEN_WIDTH-1:0]  cmd_len;
  logic [ADDR_WIDTH-1:0] ram_raddr;
  logic [WORD_WIDTH-1:0] ram_rdata;
  logic                  m_valid;
  logic                  m_ready;
  logic [WORD_WIDTH-1:0] m_data;
  logic                  m_last;

  modport master (
    input  cmd_valid, cmd_addr, cmd_len, ram_rdata, m_ready,
    output cmd_ready, ram_raddr, m_valid, m_data, m_last
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_len, ram_rdata, m_ready,
    input  cmd_ready, ram_raddr, m_valid, m_data, m_last
  );

endinterface

// File: rtl/dist_ram_rd_stream_skid_buf.sv
// rd_skid_buf_m: small register FIFO holding RAM words (with their last flag)
// between the RAM read port and the output stream.
//   clk, rst   : clock, synchronous active-high reset
//   flush      : empties the FIFO at the next edge (wins over push/pop)
//   push       : write push_data this cycle
//   push_data  : DW-bit entry
//   pop        : consume the head entry this cycle
//   pop_data   : head entry (valid when !empty)
//   count      : number of entries held
//   empty      : count == 0
module rd_skid_buf_m
  import dist_ram_pkg::*;
#(
  parameter int  DEPTH = 3,
  parameter int  DW    = 33,
  localparam int CNT_W = cnt_width(DEPTH),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [DW-1:0]    push_data,
  input  logic             pop,
  output logic [DW-1:0]    pop_data,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  logic [DW-1:0]    mem_q [DEPTH];
  logic [DW-1:0]    mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(DEPTH));
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  // A push into a full FIFO is only accepted when the head leaves the same cycle.
  assign do_push = push & (~full | pop);
  assign do_pop  = pop & ~empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/dist_ram_rd_stream_m.sv
// dist_ram_rd_stream_m: read-side engine for the inferred simple dual-port
// distributed RAM. Takes a (start address, length) command and streams
// cmd_len+1 consecutive words (addresses wrap) out as a valid/ready stream
// with m_last on the final word, hiding the RAM read latency and absorbing
// downstream backpressure.
//
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   abort      : (only with DIST_RAM_RD_STREAM_ABORT_EN) drops the current
//                burst; ignored in IDLE
//   bus        : dist_ram_rd_stream_if.master
//                cmd_valid/cmd_ready/cmd_addr/cmd_len  command channel
//                ram_raddr/ram_rdata                   RAM read port
//                m_valid/m_ready/m_data/m_last         output stream
//   dbg_state  : current FSM state
//
// Build option: define DIST_RAM_RD_STREAM_ABORT_EN to add the abort input.
module dist_ram_rd_stream_m
  import dist_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int WORD_WIDTH = 32,
  parameter int LEN_WIDTH  = 8,
  parameter int RD_LATENCY = 1
) (
  input  logic      clk,
  input  logic      rst,
`ifdef DIST_RAM_RD_STREAM_ABORT_EN
  input  logic      abort,
`endif
  dist_ram_rd_stream_if.master bus,
  output rd_state_t dbg_state
);

  localparam int BUF_DEPTH = buf_depth(RD_LATENCY);
  localparam int CNT_W     = cnt_width(BUF_DEPTH);

  rd_state_t             state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;
  logic                  rdy_en_q, rdy_en_d;

  logic                  cmd_ready_int;
  logic                  abort_hit;
  logic                  issue;
  logic                  issue_last;
  logic                  can_issue;
  logic [CNT_W:0]        pending;
  logic [CNT_W-1:0]      infl_cnt;
  logic [CNT_W-1:0]      buf_cnt;
  logic                  buf_empty;
  logic                  push_v;
  logic                  push_last;
  logic [WORD_WIDTH:0]   head;
  logic                  out_valid;

`ifdef DIST_RAM_RD_STREAM_ABORT_EN
  assign abort_hit = abort & (state_q != IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  // rdy_en_q keeps cmd_ready low for the first cycle after reset is released.
  assign cmd_ready_int = (state_q == IDLE) & rdy_en_q & ~rst;

  // Reads still inside the RAM pipeline already own a buffer slot, so an
  // issue is allowed only while buffered + in-flight words leave room.
  assign pending   = {1'b0, buf_cnt} + {1'b0, infl_cnt};
  assign can_issue = (pending < (CNT_W + 1)'(BUF_DEPTH));

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    issue      = 1'b0;
    issue_last = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid && cmd_ready_int) begin
          addr_d  = bus.cmd_addr;
          rem_d   = bus.cmd_len;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (can_issue) begin
          issue  = 1'b1;
          addr_d = addr_q + ADDR_WIDTH'(1);
          if (rem_q == '0) begin
            issue_last = 1'b1;
            state_d    = DRAIN;
          end else begin
            rem_d = rem_q - LEN_WIDTH'(1);
          end
        end
      end
      DRAIN: begin
        if (infl_cnt == '0 && buf_cnt == '0) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (abort_hit) begin
      state_d    = IDLE;
      issue      = 1'b0;
      issue_last = 1'b0;
    end
  end

  assign rdy_en_d = 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      rem_q    <= '0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      rem_q    <= rem_d;
      rdy_en_q <= rdy_en_d;
    end
  end

  // Track each issued read (and whether it is the burst's last) until the RAM
  // presents its data; the word is captured in the same cycle it appears.
  generate
    if (RD_LATENCY == 0) begin : g_comb_ram
      assign push_v    = issue;
      assign push_last = issue_last;
      assign infl_cnt  = '0;
    end else begin : g_pipe_ram
      logic [RD_LATENCY-1:0] vld_q, vld_d;
      logic [RD_LATENCY-1:0] lst_q, lst_d;

      always_comb begin
        vld_d = (vld_q << 1) | RD_LATENCY'(issue);
        lst_d = (lst_q << 1) | RD_LATENCY'(issue_last);
        if (abort_hit) begin
          vld_d = '0;
          lst_d = '0;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          vld_q <= '0;
          lst_q <= '0;
        end else begin
          vld_q <= vld_d;
          lst_q <= lst_d;
        end
      end

      assign push_v    = vld_q[RD_LATENCY-1];
      assign push_last = lst_q[RD_LATENCY-1];
      assign infl_cnt  = CNT_W'($countones(vld_q));
    end
  endgenerate

  rd_skid_buf_m #(
    .DEPTH (BUF_DEPTH),
    .DW    (WORD_WIDTH + 1)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (abort_hit),
    .push      (push_v),
    .push_data ({push_last, bus.ram_rdata}),
    .pop       (bus.m_ready & out_valid),
    .pop_data  (head),
    .count     (buf_cnt),
    .empty     (buf_empty)
  );

  // Outputs are forced quiet combinationally while reset is held.
  assign out_valid     = ~buf_empty & ~rst;
  assign bus.m_valid   = out_valid;
  assign bus.m_data    = head[WORD_WIDTH-1:0];
  assign bus.m_last    = head[WORD_WIDTH] & out_valid;
  assign bus.cmd_ready = cmd_ready_int;
  assign bus.ram_raddr = rst ? '0 : addr_q;
  assign dbg_state     = state_q;

endmodule
